// File: rtl/mips_cache_pkg.sv
// Shared types for the posted write buffer between the CPU data port and the
// Avalon bus: drain FSM state encoding, queued store entry layout, bus widths.
package mips_cache_pkg;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int BE_W    = 4;
  localparam int WADDR_W = 30;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1
  } wb_state_t;

  typedef struct packed {
    logic [WADDR_W-1:0] addr;
    logic [DATA_W-1:0]  data;
    logic [BE_W-1:0]    be;
  } wb_entry_t;

endpackage

// File: rtl/mips_wbuf_fifo.sv
// Entry storage for the write buffer: circular FIFO with head/tail/count,
// full/empty flags and a parallel word-address match over valid entries.
// Store merging into a non-in-flight entry is built in when WBUF_MERGE_EN is
// defined; otherwise every accepted store allocates a new entry.
module mips_wbuf_fifo
  import mips_cache_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [ADDR_W-1:0]      addr_i,
  input  logic [DATA_W-1:0]      data_i,
  input  logic [BE_W-1:0]        be_i,
  input  logic                   pop_i,
  input  logic                   head_busy_i,
  output wb_entry_t              head_o,
  output logic [$clog2(DEPTH):0] count_next_o,
  output logic                   match_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int PW = $clog2(DEPTH);

`ifdef WBUF_MERGE_EN
  localparam bit MERGE_EN = 1'b1;
`else
  localparam bit MERGE_EN = 1'b0;
`endif

  wb_entry_t       mem_q [DEPTH];
  logic [PW-1:0]   head_q, tail_q;
  logic [PW:0]     count_q, count_d;
  logic [DEPTH-1:0] valid, match_vec, merge_vec;
  logic [PW-1:0]   merge_idx;
  wb_entry_t       merged;
  logic            merge_hit, alloc, pop_ok;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = empty_o ? '0 : mem_q[head_q];

  // Entry validity by ring distance from head, then word-address match
  always_comb begin
    valid     = '0;
    match_vec = '0;
    merge_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid[i]     = ({1'b0, PW'(i) - head_q} < count_q);
      match_vec[i] = valid[i] && (mem_q[i].addr == addr_i[ADDR_W-1:2]);
      // The head being written on the bus must not change under the master
      merge_vec[i] = match_vec[i] && !(head_busy_i && (PW'(i) == head_q));
    end
  end

  assign match_o   = |match_vec;
  assign merge_hit = MERGE_EN && push_i && (be_i != '0) && (|merge_vec);
  assign alloc     = push_i && (be_i != '0) && !full_o && !merge_hit;
  assign pop_ok    = pop_i && !empty_o;
  assign count_d   = count_q + {{PW{1'b0}}, alloc} - {{PW{1'b0}}, pop_ok};
  assign count_next_o = count_d;

  // Merge target selection and byte-lane overlay of the new store
  always_comb begin
    merge_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (merge_vec[i]) merge_idx = PW'(i);
    end
    merged = mem_q[merge_idx];
    for (int b = 0; b < BE_W; b++) begin
      if (be_i[b]) merged.data[8*b +: 8] = data_i[8*b +: 8];
    end
    merged.be = merged.be | be_i;
  end

  // Pointer and occupancy update; reset discards every entry
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (alloc)  tail_q <= tail_q + 1'b1;
      if (pop_ok) head_q <= head_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Entry payload writes: new allocation at tail or merge into a match
  always_ff @(posedge clk) begin
    if (alloc) begin
      mem_q[tail_q] <= '{addr: addr_i[ADDR_W-1:2], data: data_i, be: be_i};
    end else if (merge_hit) begin
      mem_q[merge_idx] <= merged;
    end
  end

endmodule

// File: rtl/mips_cache_wbuf.sv
// Posted write buffer top: queues CPU stores in one cycle and drains them to
// the Avalon bus while the cache controller asserts active.
// Optional build macro: WBUF_MERGE_EN (store merging into queued entries).
//
// Bus handshake: write_writeenable is the request; a write is accepted in any
// cycle where write_writeenable=1 and waitrequest=0, and the head pops at that
// edge. While waitrequest=1 the head fields and the strobe stay unchanged,
// even if active drops; the FSM only leaves WRITE on an accepted write.
module mips_cache_wbuf
  import mips_cache_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              write_en,
  input  logic [DATA_W-1:0] writedata,
  input  logic [BE_W-1:0]   byteenable,
  input  logic              active,
  input  logic              waitrequest,
  output logic              addr_in_wb,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_data,
  output logic [BE_W-1:0]   write_byteenable,
  output logic              write_writeenable,
  output logic [1:0]        state_out,
  output logic              full,
  output logic              empty
);

  wb_state_t             state_q;
  logic                  wwe_q;
  logic                  pop;
  wb_entry_t             head;
  logic [$clog2(DEPTH):0] count_next;

  assign pop = (state_q == WRITE) && !waitrequest;

  mips_wbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (write_en),
    .addr_i       (addr),
    .data_i       (writedata),
    .be_i         (byteenable),
    .pop_i        (pop),
    .head_busy_i  (state_q == WRITE),
    .head_o       (head),
    .count_next_o (count_next),
    .match_o      (addr_in_wb),
    .full_o       (full),
    .empty_o      (empty)
  );

  assign write_addr        = {head.addr, 2'b00};
  assign write_data        = head.data;
  assign write_byteenable  = head.be;
  assign write_writeenable = wwe_q;
  assign state_out         = state_q;

  // Drain FSM: start on active with data queued, chain writes back-to-back
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wwe_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (active && !empty) begin
            state_q <= WRITE;
            wwe_q   <= 1'b1;
          end
        end
        WRITE: begin
          if (!waitrequest) begin
            if (active && (count_next != '0)) begin
              state_q <= WRITE;
              wwe_q   <= 1'b1;
            end else begin
              state_q <= IDLE;
              wwe_q   <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          wwe_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cache_wbuf.sv
// Bench for mips_cache_wbuf: directed stores, expected bus writes queued in a
// scoreboard and checked by a monitor on every accepted Avalon write.
module tb_mips_cache_wbuf;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        write_en;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        active;
  logic        waitrequest;
  logic        addr_in_wb;
  logic [31:0] write_addr;
  logic [31:0] write_data;
  logic [3:0]  write_byteenable;
  logic        write_writeenable;
  logic [1:0]  state_out;
  logic        full;
  logic        empty;

  int passed = 0;
  int total  = 0;
  logic [67:0] exp_q[$];
  logic [67:0] mon_got, mon_exp;

  mips_cache_wbuf #(.DEPTH(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .addr              (addr),
    .write_en          (write_en),
    .writedata         (writedata),
    .byteenable        (byteenable),
    .active            (active),
    .waitrequest       (waitrequest),
    .addr_in_wb        (addr_in_wb),
    .write_addr        (write_addr),
    .write_data        (write_data),
    .write_byteenable  (write_byteenable),
    .write_writeenable (write_writeenable),
    .state_out         (state_out),
    .full              (full),
    .empty             (empty)
  );

  // Clock
  always #5 clk = ~clk;

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one store for one edge; expected bus write is queued if accepted
  task automatic store(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input bit expect_accept);
    addr       = a;
    writedata  = d;
    byteenable = be;
    write_en   = 1'b1;
    if (expect_accept) exp_q.push_back({a[31:2], 2'b00, d, be});
    tick();
    write_en = 1'b0;
  endtask

  task automatic drain(input string name);
    active      = 1'b1;
    waitrequest = 1'b0;
    for (int i = 0; i < 40 && empty !== 1'b1; i++) tick();
    check(name, {31'd0, empty}, 32'd1);
    active = 1'b0;
  endtask

  // Monitor: every accepted bus write must match the oldest expected one
  always @(negedge clk) begin
    if (rst === 1'b0 && write_writeenable === 1'b1 && waitrequest === 1'b0) begin
      mon_got = {write_addr, write_data, write_byteenable};
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL bus_write: unexpected write got %h expected none", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got === mon_exp) passed++;
        else $display("FAIL bus_write: got %h expected %h", mon_got, mon_exp);
      end
    end
  end

  initial begin
    // Reset
    rst = 1'b1; addr = '0; write_en = 1'b0; writedata = '0; byteenable = '0;
    active = 1'b0; waitrequest = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_state", {30'd0, state_out}, 32'd0);
    check("rst_wwe", {31'd0, write_writeenable}, 32'd0);
    check("rst_waddr", write_addr, 32'd0);
    check("rst_match", {31'd0, addr_in_wb}, 32'd0);

    // Single store with two wait cycles
    store(32'h0000_0104, 32'hDEAD_BEEF, 4'b1111, 1'b1);
    check("single_match", {31'd0, addr_in_wb}, 32'd1);
    addr = 32'h0000_0108; #1;
    check("single_nomatch", {31'd0, addr_in_wb}, 32'd0);
    addr = 32'h0000_0104;
    active = 1'b1; waitrequest = 1'b1;
    tick();
    check("wait1_wwe", {31'd0, write_writeenable}, 32'd1);
    check("wait1_addr", write_addr, 32'h0000_0104);
    check("wait1_state", {30'd0, state_out}, 32'd1);
    tick();
    check("wait2_wwe", {31'd0, write_writeenable}, 32'd1);
    check("wait2_addr", write_addr, 32'h0000_0104);
    check("wait2_data", write_data, 32'hDEAD_BEEF);
    waitrequest = 1'b0;
    tick();
    check("single_empty", {31'd0, empty}, 32'd1);
    check("single_state", {30'd0, state_out}, 32'd0);
    check("single_wwe", {31'd0, write_writeenable}, 32'd0);
    check("single_match_gone", {31'd0, addr_in_wb}, 32'd0);
    active = 1'b0; waitrequest = 1'b1;

    // Fill to DEPTH, extra store ignored, back-to-back drain
    for (int i = 0; i < 4; i++)
      store(32'h10 + 32'(4 * i), 32'hA0A0_0000 + 32'(i), 4'b1111, 1'b1);
    check("fill_full", {31'd0, full}, 32'd1);
    store(32'h0000_0020, 32'hFFFF_FFFF, 4'b1111, 1'b0);
    check("fill_still_full", {31'd0, full}, 32'd1);
    check("fill_extra_nomatch", {31'd0, addr_in_wb}, 32'd0);
    check("fill_head", write_addr, 32'h0000_0010);
    active = 1'b1; waitrequest = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("b2b_state", {30'd0, state_out}, 32'd1);
      tick();
    end
    check("b2b_empty", {31'd0, empty}, 32'd1);
    check("b2b_idle", {30'd0, state_out}, 32'd0);
    active = 1'b0; waitrequest = 1'b1;

    // Simultaneous push and pop, then active dropped mid-write
    store(32'h0000_0040, 32'hB000_0000, 4'b1111, 1'b1);
    store(32'h0000_0044, 32'hB000_0001, 4'b1111, 1'b1);
    active = 1'b1; waitrequest = 1'b1;
    tick();
    waitrequest = 1'b0;
    store(32'h0000_0048, 32'hB000_0002, 4'b1111, 1'b1);
    check("pp_state", {30'd0, state_out}, 32'd1);
    check("pp_head", write_addr, 32'h0000_0044);
    active = 1'b0; waitrequest = 1'b1;
    tick();
    tick();
    check("drop_wwe", {31'd0, write_writeenable}, 32'd1);
    check("drop_addr", write_addr, 32'h0000_0044);
    waitrequest = 1'b0;
    tick();
    check("drop_idle", {30'd0, state_out}, 32'd0);
    check("drop_wwe_off", {31'd0, write_writeenable}, 32'd0);
    check("drop_kept_head", write_addr, 32'h0000_0048);
    check("drop_not_empty", {31'd0, empty}, 32'd0);
    waitrequest = 1'b1;
    store(32'h0000_0050, 32'hC000_0000, 4'b1111, 1'b1);
    store(32'h0000_0054, 32'hC000_0001, 4'b1111, 1'b1);
    check("pp_count_not_full", {31'd0, full}, 32'd0);
    store(32'h0000_0058, 32'hC000_0002, 4'b1111, 1'b1);
    check("pp_count_full", {31'd0, full}, 32'd1);
    drain("pp_drain");

    // Byte lanes and zero-byteenable store
    waitrequest = 1'b1;
    store(32'h0000_0200, 32'h1234_5678, 4'b0011, 1'b1);
    check("be_lanes", {28'd0, write_byteenable}, 32'h3);
    check("be_addr", write_addr, 32'h0000_0200);
    check("be_data", write_data, 32'h1234_5678);
    addr = 32'h0000_0203; #1;
    check("be_low_bits_ignored", {31'd0, addr_in_wb}, 32'd1);
    store(32'h0000_0300, 32'h5555_5555, 4'b0000, 1'b0);
    check("be0_nomatch", {31'd0, addr_in_wb}, 32'd0);
    store(32'h0000_0204, 32'hD000_0001, 4'b1100, 1'b1);
    store(32'h0000_0208, 32'hD000_0002, 4'b0001, 1'b1);
    check("be0_not_full", {31'd0, full}, 32'd0);
    store(32'h0000_020C, 32'hD000_0003, 4'b1000, 1'b1);
    check("be0_full", {31'd0, full}, 32'd1);
    drain("be_drain");

    tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
